// File: rtl/div_pkg.sv
// Shared types and constants for the iterative handshaked divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   // Every bit of a divide-by-zero quotient is filled with this value.
   localparam logic DIV0_Q_BIT = 1'b1;

   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation of a wide and a narrow lane.
// Used for operand magnitudes on entry and for sign correction on exit.
module div_sign_fix #(
   parameter int WA = 40,
   parameter int WB = 32
) (
   input  logic [WA-1:0] wide_in,
   input  logic          wide_neg,
   input  logic [WB-1:0] narrow_in,
   input  logic          narrow_neg,
   output logic [WA-1:0] wide_out,
   output logic [WB-1:0] narrow_out
);

   assign wide_out   = wide_neg   ? -wide_in   : wide_in;
   assign narrow_out = narrow_neg ? -narrow_in : narrow_in;

endmodule

// File: rtl/div_iter_hs.sv
// Handshaked restoring divider: one quotient bit per cycle, MSB first,
// with optional two's-complement sign handling and a pass-through tag.
module div_iter_hs
   import div_pkg::*;
#(
   parameter int A_WIDTH   = 40,
   parameter int B_WIDTH   = 32,
   parameter int TC_MODE   = 0,
   parameter int TAG_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [A_WIDTH-1:0]   a,
   input  logic [B_WIDTH-1:0]   b,
   input  logic [TAG_WIDTH-1:0] tag_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [A_WIDTH-1:0]   quotient,
   output logic [B_WIDTH-1:0]   remainder,
   output logic                 divide_by_0,
   output logic [TAG_WIDTH-1:0] tag_out
);

   localparam int CW = cnt_width(A_WIDTH);

   state_t state, state_next;

   logic [A_WIDTH-1:0]   dvd;        // dividend shifts out, quotient shifts in
   logic [B_WIDTH-1:0]   dvs;
   logic [B_WIDTH-1:0]   prem;
   logic                 sign_a, sign_b;
   logic [TAG_WIDTH-1:0] tag_q;
   logic [CW-1:0]        cnt;

   logic                 b_zero, neg_a, neg_b;
   logic [A_WIDTH-1:0]   a_mag, q_fix;
   logic [B_WIDTH-1:0]   b_mag, r_fix, diff;
   logic [B_WIDTH:0]     trial;
   logic                 ge;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign b_zero    = (b == '0);
   assign neg_a     = (TC_MODE != 0) && a[A_WIDTH-1];
   assign neg_b     = (TC_MODE != 0) && b[B_WIDTH-1];

   div_sign_fix #(.WA(A_WIDTH), .WB(B_WIDTH)) u_abs (
      .wide_in    (a),
      .wide_neg   (neg_a),
      .narrow_in  (b),
      .narrow_neg (neg_b),
      .wide_out   (a_mag),
      .narrow_out (b_mag)
   );

   div_sign_fix #(.WA(A_WIDTH), .WB(B_WIDTH)) u_fix (
      .wide_in    (dvd),
      .wide_neg   (sign_a ^ sign_b),
      .narrow_in  (prem),
      .narrow_neg (sign_a),
      .wide_out   (q_fix),
      .narrow_out (r_fix)
   );

   // The true difference always fits in B_WIDTH bits whenever it is kept.
   assign trial = {prem, dvd[A_WIDTH-1]};
   assign ge    = (trial >= {1'b0, dvs});
   assign diff  = trial[B_WIDTH-1:0] - dvs;

   always_comb begin
      // NOTE: default first so every path assigns state_next and no latch is inferred.
      state_next = state;
      unique case (state)
         IDLE:    if (in_valid) state_next = b_zero ? DONE : CALC;
         CALC:    if (cnt == '0) state_next = FIX;
         FIX:     state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         quotient    <= '0;
         remainder   <= '0;
         divide_by_0 <= 1'b0;
         tag_out     <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && in_valid && b_zero) begin
            quotient    <= {A_WIDTH{DIV0_Q_BIT}};
            remainder   <= a[B_WIDTH-1:0];
            divide_by_0 <= 1'b1;
            tag_out     <= tag_in;
         end else if (state == FIX) begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            divide_by_0 <= 1'b0;
            tag_out     <= tag_q;
         end
      end
   end

   // NOTE: working registers carry no reset; they are always loaded on accept before use.
   always_ff @(posedge clk) begin
      unique case (state)
         IDLE: if (in_valid) begin
            dvd    <= a_mag;
            dvs    <= b_mag;
            prem   <= '0;
            sign_a <= neg_a;
            sign_b <= neg_b;
            tag_q  <= tag_in;
            cnt    <= CW'(A_WIDTH - 1);
         end
         CALC: begin
            prem <= ge ? diff : trial[B_WIDTH-1:0];
            dvd  <= {dvd[A_WIDTH-2:0], ge};
            cnt  <= cnt - 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_div_iter_hs.sv
// Scoreboard bench: an unsigned and a two's-complement divider driven with
// directed vectors; a per-instance monitor pops and checks every result handshake.
module tb_div_iter_hs;

   localparam int AW = 40;
   localparam int BW = 32;
   localparam int TW = 4;

   typedef struct packed {
      logic [AW-1:0] q;
      logic [BW-1:0] r;
      logic          d0;
      logic [TW-1:0] tag;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid_u, in_valid_s, out_ready;
   logic [AW-1:0] a;
   logic [BW-1:0] b;
   logic [TW-1:0] tag;

   logic          in_ready_u, out_valid_u, d0_u;
   logic [AW-1:0] q_u;
   logic [BW-1:0] r_u;
   logic [TW-1:0] tag_u;
   logic          in_ready_s, out_valid_s, d0_s;
   logic [AW-1:0] q_s;
   logic [BW-1:0] r_s;
   logic [TW-1:0] tag_s;

   exp_t sb_u[$];
   exp_t sb_s[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   lat;

   always #5 clk = ~clk;

   div_iter_hs #(.A_WIDTH(AW), .B_WIDTH(BW), .TC_MODE(0), .TAG_WIDTH(TW)) u_dut_u (
      .clk(clk), .rst(rst), .in_valid(in_valid_u), .in_ready(in_ready_u),
      .a(a), .b(b), .tag_in(tag), .out_valid(out_valid_u), .out_ready(out_ready),
      .quotient(q_u), .remainder(r_u), .divide_by_0(d0_u), .tag_out(tag_u)
   );

   div_iter_hs #(.A_WIDTH(AW), .B_WIDTH(BW), .TC_MODE(1), .TAG_WIDTH(TW)) u_dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
      .a(a), .b(b), .tag_in(tag), .out_valid(out_valid_s), .out_ready(out_ready),
      .quotient(q_s), .remainder(r_s), .divide_by_0(d0_s), .tag_out(tag_s)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [AW-1:0] q, input logic [BW-1:0] r,
                               input logic d0, input logic [TW-1:0] t);
      exp_t e;
      e.q = q; e.r = r; e.d0 = d0; e.tag = t;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid_u && out_ready) begin
         if (sb_u.size() == 0) check("u_unexpected_result", 64'd1, 64'd0);
         else begin
            e = sb_u.pop_front();
            check("u_quotient", q_u, e.q);
            check("u_remainder", r_u, e.r);
            check("u_div0", d0_u, e.d0);
            check("u_tag", tag_u, e.tag);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid_s && out_ready) begin
         if (sb_s.size() == 0) check("s_unexpected_result", 64'd1, 64'd0);
         else begin
            e = sb_s.pop_front();
            check("s_quotient", q_s, e.q);
            check("s_remainder", r_s, e.r);
            check("s_div0", d0_s, e.d0);
            check("s_tag", tag_s, e.tag);
         end
      end
   end

   // Called #1 after a rising edge; returns #1 after the accepting edge.
   task automatic issue(input bit sel, input logic [AW-1:0] av, input logic [BW-1:0] bv,
                        input logic [TW-1:0] tv, input bit push, input exp_t e);
      int n = 0;
      while (!(sel ? in_ready_s : in_ready_u) && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 200) check("issue_timeout", 64'd0, 64'd1);
      a = av; b = bv; tag = tv;
      if (sel) in_valid_s = 1'b1; else in_valid_u = 1'b1;
      if (push) begin
         if (sel) sb_s.push_back(e); else sb_u.push_back(e);
      end
      @(posedge clk); #1;
      in_valid_s = 1'b0;
      in_valid_u = 1'b0;
   endtask

   // Edges from the accepting edge to the first edge that samples out_valid high.
   task automatic wait_valid(input bit sel, output int l);
      l = 1;
      while (!(sel ? out_valid_s : out_valid_u) && l < 200) begin
         @(posedge clk); #1; l++;
      end
      if (l >= 200) check("valid_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid_u = 1'b0; in_valid_s = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; tag = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid_u, 0);
      check("rst_quotient", q_u, 0);
      check("rst_remainder", r_u, 0);
      check("rst_div0", d0_u, 0);
      check("rst_tag", tag_u, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_in_ready", in_ready_u, 1);

      // Unsigned vectors
      issue(0, 40'd1000, 32'd7, 4'd3, 1, mk(40'd142, 32'd6, 1'b0, 4'd3));
      wait_valid(0, lat);
      check("u_latency", lat, 42);
      issue(0, 40'd5, 32'd0, 4'd5, 1, mk({AW{1'b1}}, 32'd5, 1'b1, 4'd5));
      wait_valid(0, lat);
      check("u_div0_latency", lat, 1);
      issue(0, 40'd12345, 32'd1, 4'd6, 1, mk(40'd12345, 32'd0, 1'b0, 4'd6));
      issue(0, 40'hFF_FFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 1, mk(40'd256, 32'd255, 1'b0, 4'd7));

      // Two's-complement vectors
      issue(1, -40'sd7, 32'd2, 4'd1, 1, mk(-40'sd3, -32'sd1, 1'b0, 4'd1));
      wait_valid(1, lat);
      check("s_latency", lat, 42);
      issue(1, 40'd7, -32'sd2, 4'd2, 1, mk(-40'sd3, 32'd1, 1'b0, 4'd2));
      issue(1, 40'h80_0000_0000, -32'sd1, 4'd8, 1, mk(40'h80_0000_0000, 32'd0, 1'b0, 4'd8));
      issue(1, -40'sd100, 32'd7, 4'd10, 1, mk(-40'sd14, -32'sd2, 1'b0, 4'd10));
      issue(1, -40'sd7, 32'd0, 4'd12, 1, mk({AW{1'b1}}, 32'hFFFF_FFF9, 1'b1, 4'd12));
      wait_valid(1, lat);
      @(posedge clk); #1;

      // Back-pressure: result held 10 cycles while a new request is offered
      out_ready = 1'b0;
      issue(0, 40'd500, 32'd10, 4'd9, 1, mk(40'd50, 32'd0, 1'b0, 4'd9));
      wait_valid(0, lat);
      for (int i = 0; i < 10; i++) begin
         in_valid_u = 1'b1; a = 40'd77; b = 32'd0; tag = 4'd2;
         @(posedge clk); #1;
         check("bp_out_valid", out_valid_u, 1);
         check("bp_in_ready", in_ready_u, 0);
         check("bp_quotient", q_u, 50);
         check("bp_remainder", r_u, 0);
         check("bp_div0", d0_u, 0);
         check("bp_tag", tag_u, 9);
      end
      in_valid_u = 1'b0;
      out_ready  = 1'b1;
      @(posedge clk); #1;
      check("bp_in_ready_after", in_ready_u, 1);
      check("bp_out_valid_after", out_valid_u, 0);

      // Reset in the middle of CALC drops the operation
      issue(0, 40'd1000, 32'd3, 4'd4, 0, mk('0, '0, 1'b0, '0));
      repeat (19) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("mid_rst_out_valid", out_valid_u, 0);
      check("mid_rst_quotient", q_u, 0);
      check("mid_rst_remainder", r_u, 0);
      check("mid_rst_div0", d0_u, 0);
      check("mid_rst_tag", tag_u, 0);
      check("mid_rst_in_ready", in_ready_u, 1);
      repeat (30) @(posedge clk);
      #1;
      check("mid_rst_no_result", out_valid_u, 0);
      issue(0, 40'd100, 32'd9, 4'd11, 1, mk(40'd11, 32'd1, 1'b0, 4'd11));
      wait_valid(0, lat);
      check("post_rst_latency", lat, 42);

      for (int i = 0; i < 100 && (sb_u.size() + sb_s.size()) != 0; i++) @(posedge clk);
      #1;
      check("scoreboard_drained", sb_u.size() + sb_s.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
